// File: rtl/hpm_counter_bank_pkg.sv
// Shared definitions for the machine-mode performance monitor bank:
// CSR addresses, privilege encoding and register-kind decode helpers.
package hpm_counter_bank_pkg;

  typedef enum logic [11:0] {
    CSR_MCOUNTEREN    = 12'h306,
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MHPMEVENT3    = 12'h323,
    CSR_MCYCLE        = 12'hB00,
    CSR_MINSTRET      = 12'hB02,
    CSR_MHPMCOUNTER3  = 12'hB03,
    CSR_CYCLE         = 12'hC00,
    CSR_TIME          = 12'hC01,
    CSR_INSTRET       = 12'hC02,
    CSR_HPMCOUNTER3   = 12'hC03
  } csr_addr_e;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } priv_lvl_t;

  typedef enum logic [2:0] {
    REG_NONE = 3'd0,
    REG_MCNT = 3'd1,
    REG_UCNT = 3'd2,
    REG_INH  = 3'd3,
    REG_EVT  = 3'd4,
    REG_EN   = 3'd5
  } reg_kind_e;

  localparam int HPM_BASE_IDX = 3;
  localparam int MAX_HPM      = 29;
  localparam int EVT_SEL_W    = 8;

  // Counter slot k exists: cycle (0), instret (2) or an implemented HPM.
  function automatic logic cnt_implemented(input logic [4:0] idx, input int num_hpm);
    int k;
    k = int'(idx);
    return (k == 0) || (k == 2) ||
           ((k >= HPM_BASE_IDX) && (k < HPM_BASE_IDX + num_hpm));
  endfunction

endpackage

// File: rtl/hpm_counter_bank_counter.sv
// Single free-running counter with software load and sticky wrap flag.
module hpm_counter
  import hpm_counter_bank_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc_i,
  input  logic                 wr_en_i,
  input  logic [CNT_WIDTH-1:0] wdata_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;

  // A software load takes priority over the increment and clears the wrap flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (wr_en_i) begin
      r_cnt <= wdata_i;
      r_ovf <= 1'b0;
    end else if (inc_i) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
      r_ovf <= r_ovf | (&r_cnt);
    end else begin
      r_cnt <= r_cnt;
      r_ovf <= r_ovf;
    end
  end

  assign cnt_o = r_cnt;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/hpm_counter_bank.sv
// Machine-mode performance counter bank: mcycle, minstret and NUM_HPM
// event-selected counters with inhibit, user shadows and a 1-cycle CSR port.
module hpm_counter_bank
  import hpm_counter_bank_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int NUM_HPM    = 14,
  parameter int NUM_EVENTS = 16,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [11:0]           csr_addr_i,
  input  logic                  csr_rd_en_i,
  input  logic                  csr_wr_en_i,
  input  logic [XLEN-1:0]       csr_wdata_i,
  input  logic [1:0]            priv_lvl_i,
  input  logic                  retire_i,
  input  logic [NUM_EVENTS-1:0] events_i,
  output logic [XLEN-1:0]       csr_rdata_o,
  output logic                  csr_rvalid_o,
  output logic                  csr_illegal_o,
  output logic [NUM_HPM-1:0]    ovf_o
);

  // Slot k of the enable/inhibit layout; slot 1 (time) is a hole.
  localparam int              CEN_W    = NUM_HPM + HPM_BASE_IDX;
  localparam logic [CEN_W-1:0] CEN_MASK = {{(CEN_W-2){1'b1}}, 2'b01};

  logic [CEN_W-1:0]     r_inhibit;
  logic [CEN_W-1:0]     r_counteren;
  logic [EVT_SEL_W-1:0] r_event [NUM_HPM];
  logic [XLEN-1:0]      r_rdata;
  logic                 r_rvalid;
  logic                 r_illegal;

  logic [CNT_WIDTH-1:0] w_cnt [CEN_W];
  logic [CEN_W-1:0]     w_ovf;
  logic                 w_unused_ovf;

  reg_kind_e            w_kind;
  logic [4:0]           w_idx;
  logic [11:0]          w_page;
  logic                 w_illegal;
  logic                 w_wr_ok;
  logic [CNT_WIDTH-1:0] w_cnt_sel;
  logic [EVT_SEL_W-1:0] w_evt_sel;
  logic                 w_en_bit;
  logic [XLEN-1:0]      w_rval;

  function automatic logic event_hit(input logic [EVT_SEL_W-1:0] sel,
                                     input logic [NUM_EVENTS-1:0] ev);
    logic hit;
    hit = 1'b0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      hit = hit | ((sel == EVT_SEL_W'(e + 1)) & ev[e]);
    end
    return hit;
  endfunction

  // Address decode and selection of the addressed register's current value.
  always_comb begin
    w_idx     = csr_addr_i[4:0];
    w_page    = {csr_addr_i[11:5], 5'b00000};
    w_cnt_sel = '0;
    w_evt_sel = '0;
    w_en_bit  = 1'b0;
    for (int k = 0; k < CEN_W; k++) begin
      w_cnt_sel = w_cnt_sel | ((w_idx == 5'(k)) ? w_cnt[k] : '0);
      w_en_bit  = w_en_bit | ((w_idx == 5'(k)) & r_counteren[k]);
    end
    for (int i = 0; i < NUM_HPM; i++) begin
      w_evt_sel = w_evt_sel | ((w_idx == 5'(HPM_BASE_IDX + i)) ? r_event[i] : '0);
    end

    if (w_page == CSR_MCYCLE) begin
      w_kind = cnt_implemented(w_idx, NUM_HPM) ? REG_MCNT : REG_NONE;
    end else if (w_page == CSR_CYCLE) begin
      w_kind = cnt_implemented(w_idx, NUM_HPM) ? REG_UCNT : REG_NONE;
    end else if (csr_addr_i == CSR_MCOUNTEREN) begin
      w_kind = REG_EN;
    end else if (csr_addr_i == CSR_MCOUNTINHIBIT) begin
      w_kind = REG_INH;
    end else if ((w_page == CSR_MCOUNTINHIBIT) && cnt_implemented(w_idx, NUM_HPM) &&
                 (w_idx >= 5'(HPM_BASE_IDX))) begin
      w_kind = REG_EVT;
    end else begin
      w_kind = REG_NONE;
    end

    // Lower privileges may only read enabled user shadows.
    case (priv_lvl_i)
      PRIV_M:         w_illegal = (w_kind == REG_NONE) || ((w_kind == REG_UCNT) && csr_wr_en_i);
      PRIV_U, PRIV_S: w_illegal = !((w_kind == REG_UCNT) && !csr_wr_en_i && w_en_bit);
      default:        w_illegal = 1'b1;
    endcase

    case (w_kind)
      REG_MCNT, REG_UCNT: w_rval = XLEN'(w_cnt_sel);
      REG_INH:            w_rval = XLEN'(r_inhibit);
      REG_EN:             w_rval = XLEN'(r_counteren);
      REG_EVT:            w_rval = XLEN'(w_evt_sel);
      default:            w_rval = '0;
    endcase

    w_wr_ok = csr_wr_en_i & ~w_illegal;
  end

  for (genvar k = 0; k < CEN_W; k++) begin : g_slot
    if (k == 1) begin : g_hole
      assign w_cnt[k] = '0;
      assign w_ovf[k] = 1'b0;
    end else begin : g_ctr
      logic w_inc;
      logic w_wr;
      if (k == 0) begin : g_cycle
        assign w_inc = ~r_inhibit[0];
      end else if (k == 2) begin : g_instret
        assign w_inc = retire_i & ~r_inhibit[2];
      end else begin : g_hpm
        assign w_inc = event_hit(r_event[k-HPM_BASE_IDX], events_i) & ~r_inhibit[k];
      end
      assign w_wr = w_wr_ok && (w_kind == REG_MCNT) && (w_idx == 5'(k));
      hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (w_inc),
        .wr_en_i (w_wr),
        .wdata_i (csr_wdata_i[CNT_WIDTH-1:0]),
        .cnt_o   (w_cnt[k]),
        .ovf_o   (w_ovf[k])
      );
    end
  end

  // Configuration registers: inhibit, user enable and event selectors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inhibit   <= '0;
      r_counteren <= '0;
      for (int i = 0; i < NUM_HPM; i++) r_event[i] <= '0;
    end else begin
      if (w_wr_ok && (w_kind == REG_INH)) r_inhibit <= csr_wdata_i[CEN_W-1:0] & CEN_MASK;
      if (w_wr_ok && (w_kind == REG_EN)) r_counteren <= csr_wdata_i[CEN_W-1:0] & CEN_MASK;
      for (int i = 0; i < NUM_HPM; i++) begin
        if (w_wr_ok && (w_kind == REG_EVT) && (w_idx == 5'(HPM_BASE_IDX + i)))
          r_event[i] <= csr_wdata_i[EVT_SEL_W-1:0];
      end
    end
  end

  // Response register: reads return the pre-write value one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid  <= 1'b0;
      r_illegal <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid  <= csr_rd_en_i | csr_wr_en_i;
      r_illegal <= (csr_rd_en_i | csr_wr_en_i) & w_illegal;
      r_rdata   <= (csr_rd_en_i && !w_illegal) ? w_rval : '0;
    end
  end

  assign w_unused_ovf  = ^w_ovf[2:0];
  assign ovf_o         = w_ovf[CEN_W-1:HPM_BASE_IDX];
  assign csr_rdata_o   = r_rdata;
  assign csr_rvalid_o  = r_rvalid;
  assign csr_illegal_o = r_illegal;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Self-checking bench for hpm_counter_bank: directed scenarios plus a
// randomized run against a register-map level reference model.
module tb_hpm_counter_bank;

  localparam int XLEN       = 64;
  localparam int NUM_HPM    = 14;
  localparam int NUM_EVENTS = 16;
  localparam int CNT_WIDTH  = 64;
  localparam int NBITS      = NUM_HPM + 3;
  localparam logic [31:0] IMPL_MASK = ((32'd1 << NBITS) - 32'd1) & ~32'd2;
  localparam logic [63:0] ONES = {64{1'b1}};
  localparam logic [1:0] PM = 2'd3;
  localparam logic [1:0] PU = 2'd0;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [11:0]           csr_addr_i = 12'h000;
  logic                  csr_rd_en_i = 1'b0;
  logic                  csr_wr_en_i = 1'b0;
  logic [XLEN-1:0]       csr_wdata_i = 64'd0;
  logic [1:0]            priv_lvl_i = 2'd3;
  logic                  retire_i = 1'b0;
  logic [NUM_EVENTS-1:0] events_i = 16'd0;
  logic [XLEN-1:0]       csr_rdata_o;
  logic                  csr_rvalid_o;
  logic                  csr_illegal_o;
  logic [NUM_HPM-1:0]    ovf_o;

  int total = 0;
  int bad = 0;

  logic [63:0]        m_cnt [0:31];
  logic [7:0]         m_evt [0:31];
  logic [31:0]        m_inh;
  logic [31:0]        m_en;
  logic [NUM_HPM-1:0] m_ovf;
  bit                 exp_v;
  bit                 exp_ill;
  logic [63:0]        exp_d;

  hpm_counter_bank #(
    .XLEN(XLEN), .NUM_HPM(NUM_HPM), .NUM_EVENTS(NUM_EVENTS), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_addr_i    (csr_addr_i),
    .csr_rd_en_i   (csr_rd_en_i),
    .csr_wr_en_i   (csr_wr_en_i),
    .csr_wdata_i   (csr_wdata_i),
    .priv_lvl_i    (priv_lvl_i),
    .retire_i      (retire_i),
    .events_i      (events_i),
    .csr_rdata_o   (csr_rdata_o),
    .csr_rvalid_o  (csr_rvalid_o),
    .csr_illegal_o (csr_illegal_o),
    .ovf_o         (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_cnt[k] = 64'd0;
      m_evt[k] = 8'd0;
    end
    m_inh = 32'd0;
    m_en  = 32'd0;
    m_ovf = '0;
  endtask

  function automatic bit cnt_exists(input int k);
    return (k == 0) || (k == 2) || (k >= 3 && k < 3 + NUM_HPM);
  endfunction

  // One clock of stimulus; computes the expected response and advances the model.
  task automatic cycle(input logic [11:0] a, input bit rd, input bit wr, input logic [63:0] wd,
                       input logic [1:0] pv, input bit ret, input logic [15:0] ev);
    int k;
    bit is_m, is_u, is_en, is_inh, is_evt, hit, ill, wr_ok, inc;
    logic [63:0] val;
    int s;
    k      = int'(a) & 31;
    is_m   = (a >= 12'hB00) && (a <= 12'hB1F) && cnt_exists(int'(a - 12'hB00));
    is_u   = (a >= 12'hC00) && (a <= 12'hC1F) && cnt_exists(int'(a - 12'hC00));
    is_en  = (a == 12'h306);
    is_inh = (a == 12'h320);
    is_evt = (a >= 12'h323) && (a < 12'h323 + 12'(NUM_HPM));
    hit    = is_m || is_u || is_en || is_inh || is_evt;
    if (pv == 2'd3) ill = !hit || (is_u && wr);
    else if (pv == 2'd2) ill = 1'b1;
    else ill = !(is_u && !wr && m_en[k]);
    if (is_m || is_u) val = m_cnt[k];
    else if (is_en) val = {32'd0, m_en};
    else if (is_inh) val = {32'd0, m_inh};
    else if (is_evt) val = {56'd0, m_evt[k]};
    else val = 64'd0;
    exp_v   = rd || wr;
    exp_ill = exp_v && ill;
    exp_d   = (rd && !ill) ? val : 64'd0;

    csr_addr_i = a; csr_rd_en_i = rd; csr_wr_en_i = wr; csr_wdata_i = wd;
    priv_lvl_i = pv; retire_i = ret; events_i = ev;

    wr_ok = wr && !ill;
    for (int c = 0; c < 3 + NUM_HPM; c++) begin
      if (cnt_exists(c)) begin
        if (c == 0) inc = !m_inh[0];
        else if (c == 2) inc = ret && !m_inh[2];
        else begin
          s   = int'(m_evt[c]);
          inc = (s >= 1) && (s <= NUM_EVENTS) && ev[s-1] && !m_inh[c];
        end
        if (wr_ok && is_m && k == c) begin
          m_cnt[c] = wd;
          if (c >= 3) m_ovf[c-3] = 1'b0;
        end else if (inc) begin
          if (c >= 3 && m_cnt[c] == ONES) m_ovf[c-3] = 1'b1;
          m_cnt[c] = m_cnt[c] + 64'd1;
        end
      end
    end
    if (wr_ok && is_inh) m_inh = wd[31:0] & IMPL_MASK;
    if (wr_ok && is_en)  m_en  = wd[31:0] & IMPL_MASK;
    if (wr_ok && is_evt) m_evt[k] = wd[7:0];

    @(posedge clk);
    #1;
    csr_rd_en_i = 1'b0; csr_wr_en_i = 1'b0; retire_i = 1'b0; events_i = 16'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (csr_rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b want=0", csr_rvalid_o); end
    total++; if (csr_illegal_o !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b want=0", csr_illegal_o); end
    total++; if (csr_rdata_o !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%h want=0", csr_rdata_o); end
    total++; if (ovf_o !== '0) begin bad++; $display("FAIL reset_ovf got=%h want=0", ovf_o); end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_mcycle_idle();
    repeat (10) cycle(12'h000, 1'b0, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    cycle(12'hB00, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++;
    if (csr_rdata_o !== 64'd10 || csr_rvalid_o !== 1'b1 || csr_illegal_o !== 1'b0) begin
      bad++; $display("FAIL mcycle_after_idle got=%0d v=%0b ill=%0b want=10 v=1 ill=0",
                      csr_rdata_o, csr_rvalid_o, csr_illegal_o);
    end
    for (int k = 2; k < 3 + NUM_HPM; k++) begin
      cycle(12'hB00 + 12'(k), 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
      total++;
      if (csr_rdata_o !== 64'd0 || csr_illegal_o !== 1'b0) begin
        bad++; $display("FAIL reset_counter_%0d got=%h ill=%0b want=0", k, csr_rdata_o, csr_illegal_o);
      end
    end
    cycle(12'h000, 1'b0, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_rvalid_o !== 1'b0) begin bad++; $display("FAIL idle_rvalid got=%0b want=0", csr_rvalid_o); end
  endtask

  task automatic test_event_count();
    cycle(12'h323, 1'b0, 1'b1, 64'd5, PM, 1'b0, 16'd0);
    total++;
    if (csr_rvalid_o !== 1'b1 || csr_rdata_o !== 64'd0 || csr_illegal_o !== 1'b0) begin
      bad++; $display("FAIL write_only_resp v=%0b d=%h ill=%0b want v=1 d=0 ill=0",
                      csr_rvalid_o, csr_rdata_o, csr_illegal_o);
    end
    repeat (7) cycle(12'h000, 1'b0, 1'b0, 64'd0, PM, 1'b0, 16'h0010);
    cycle(12'h000, 1'b0, 1'b0, 64'd0, PM, 1'b0, 16'h0008);
    cycle(12'hB03, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_rdata_o !== 64'd7) begin bad++; $display("FAIL event_count got=%0d want=7", csr_rdata_o); end
    cycle(12'h323, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_rdata_o !== 64'd5) begin bad++; $display("FAIL event_sel_read got=%0d want=5", csr_rdata_o); end
  endtask

  task automatic test_overflow();
    cycle(12'hB03, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, PM, 1'b0, 16'd0);
    cycle(12'h000, 1'b0, 1'b0, 64'd0, PM, 1'b0, 16'h0010);
    total++; if (ovf_o[0] !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b want=0", ovf_o[0]); end
    cycle(12'h000, 1'b0, 1'b0, 64'd0, PM, 1'b0, 16'h0010);
    total++; if (ovf_o[0] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", ovf_o[0]); end
    cycle(12'hB03, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_rdata_o !== 64'd0) begin bad++; $display("FAIL wrap_value got=%h want=0", csr_rdata_o); end
    total++; if (ovf_o[0] !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", ovf_o[0]); end
    cycle(12'hB03, 1'b0, 1'b1, 64'd0, PM, 1'b0, 16'd0);
    total++; if (ovf_o[0] !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b want=0", ovf_o[0]); end
  endtask

  task automatic test_inhibit();
    logic [63:0] v1;
    logic [63:0] v2;
    cycle(12'h320, 1'b0, 1'b1, 64'd1, PM, 1'b0, 16'd0);
    cycle(12'hB00, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    v1 = csr_rdata_o;
    repeat (5) cycle(12'h000, 1'b0, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    cycle(12'hB00, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    v2 = csr_rdata_o;
    total++; if (v2 !== v1) begin bad++; $display("FAIL inhibit_frozen got=%0d want=%0d", v2, v1); end
    cycle(12'h320, 1'b0, 1'b1, 64'd0, PM, 1'b0, 16'd0);
    repeat (3) cycle(12'h000, 1'b0, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    cycle(12'hB00, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_rdata_o !== v1 + 64'd3) begin bad++; $display("FAIL inhibit_resume got=%0d want=%0d", csr_rdata_o, v1 + 64'd3); end
  endtask

  task automatic test_rw_simul();
    cycle(12'hB03, 1'b0, 1'b1, 64'd50, PM, 1'b0, 16'd0);
    cycle(12'hB03, 1'b1, 1'b1, 64'd100, PM, 1'b0, 16'h0010);
    total++; if (csr_rdata_o !== 64'd50) begin bad++; $display("FAIL rw_old_value got=%0d want=50", csr_rdata_o); end
    cycle(12'hB03, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_rdata_o !== 64'd100) begin bad++; $display("FAIL rw_new_value got=%0d want=100", csr_rdata_o); end
  endtask

  task automatic test_priv();
    cycle(12'hC03, 1'b1, 1'b0, 64'd0, PU, 1'b0, 16'd0);
    total++; if (csr_illegal_o !== 1'b1 || csr_rvalid_o !== 1'b1) begin bad++; $display("FAIL u_read_disabled ill=%0b v=%0b want 1 1", csr_illegal_o, csr_rvalid_o); end
    cycle(12'h306, 1'b0, 1'b1, 64'h8, PM, 1'b0, 16'd0);
    cycle(12'hC03, 1'b1, 1'b0, 64'd0, PU, 1'b0, 16'd0);
    total++; if (csr_illegal_o !== 1'b0 || csr_rdata_o !== 64'd100) begin bad++; $display("FAIL u_read_enabled ill=%0b d=%0d want 0 100", csr_illegal_o, csr_rdata_o); end
    cycle(12'hC00, 1'b0, 1'b1, 64'd12345, PM, 1'b0, 16'd0);
    total++; if (csr_illegal_o !== 1'b1) begin bad++; $display("FAIL c_write_illegal got=%0b want=1", csr_illegal_o); end
    cycle(12'hB00, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_rdata_o !== exp_d) begin bad++; $display("FAIL c_write_no_effect got=%0d want=%0d", csr_rdata_o, exp_d); end
    cycle(12'hB00, 1'b1, 1'b0, 64'd0, PU, 1'b0, 16'd0);
    total++; if (csr_illegal_o !== 1'b1) begin bad++; $display("FAIL u_read_mcnt got=%0b want=1", csr_illegal_o); end
    cycle(12'hB00, 1'b1, 1'b0, 64'd0, 2'd2, 1'b0, 16'd0);
    total++; if (csr_illegal_o !== 1'b1) begin bad++; $display("FAIL priv2_access got=%0b want=1", csr_illegal_o); end
    cycle(12'hC01, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_illegal_o !== 1'b1) begin bad++; $display("FAIL time_read got=%0b want=1", csr_illegal_o); end
    cycle(12'hB03 + 12'(NUM_HPM), 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_illegal_o !== 1'b1) begin bad++; $display("FAIL beyond_hpm got=%0b want=1", csr_illegal_o); end
    cycle(12'hB02 + 12'(NUM_HPM), 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_illegal_o !== 1'b0) begin bad++; $display("FAIL last_hpm got=%0b want=0", csr_illegal_o); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] prev;
    cycle(12'hB00, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    prev = csr_rdata_o;
    for (int n = 0; n < 4; n++) begin
      cycle(12'hB00, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
      total++; if (csr_rdata_o !== prev + 64'd1) begin bad++; $display("FAIL back_to_back_%0d got=%0d want=%0d", n, csr_rdata_o, prev + 64'd1); end
      prev = csr_rdata_o;
    end
  endtask

  task automatic test_mid_reset();
    cycle(12'h324, 1'b0, 1'b1, 64'd2, PM, 1'b0, 16'd0);
    cycle(12'hB04, 1'b0, 1'b1, ONES, PM, 1'b0, 16'd0);
    cycle(12'hB04, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'h0002);
    total++; if (ovf_o[1] !== 1'b1) begin bad++; $display("FAIL pre_reset_ovf got=%0b want=1", ovf_o[1]); end
    reset_n = 1'b0;
    #1;
    total++; if (ovf_o !== '0 || csr_rvalid_o !== 1'b0) begin bad++; $display("FAIL mid_reset ovf=%h v=%0b want 0 0", ovf_o, csr_rvalid_o); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    cycle(12'h324, 1'b1, 1'b0, 64'd0, PM, 1'b0, 16'd0);
    total++; if (csr_rdata_o !== 64'd0 || csr_rvalid_o !== 1'b1) begin bad++; $display("FAIL post_reset_evt d=%h v=%0b want 0 1", csr_rdata_o, csr_rvalid_o); end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [63:0] wd;
    logic [1:0]  pv;
    int r;
    bit rd, wr;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 7))
        0:       a = 12'hB00 + 12'($urandom_range(0, 18));
        1:       a = 12'hC00 + 12'($urandom_range(0, 18));
        2:       a = 12'h320 + 12'($urandom_range(0, 19));
        3:       a = 12'h306;
        4:       a = 12'h320;
        5:       a = 12'($urandom_range(0, 4095));
        default: a = 12'hB03 + 12'($urandom_range(0, 3));
      endcase
      r  = $urandom_range(0, 9);
      pv = (r < 6) ? 2'd3 : (r < 8) ? 2'd0 : (r == 8) ? 2'd1 : 2'd2;
      r  = $urandom_range(0, 3);
      rd = (r == 1) || (r == 3);
      wr = (r >= 2);
      case ($urandom_range(0, 3))
        0:       wd = {32'($urandom), 32'($urandom)};
        1:       wd = ONES - 64'($urandom_range(0, 3));
        2:       wd = 64'($urandom_range(0, 20));
        default: wd = 64'd0;
      endcase
      cycle(a, rd, wr, wd, pv, 1'($urandom_range(0, 1)), 16'($urandom));
      total++; if (csr_rvalid_o !== exp_v) begin bad++; $display("FAIL rnd_rvalid n=%0d a=%h got=%0b want=%0b", n, a, csr_rvalid_o, exp_v); end
      total++; if (csr_illegal_o !== exp_ill) begin bad++; $display("FAIL rnd_illegal n=%0d a=%h pv=%0d got=%0b want=%0b", n, a, pv, csr_illegal_o, exp_ill); end
      if (exp_v && !exp_ill) begin
        total++; if (csr_rdata_o !== exp_d) begin bad++; $display("FAIL rnd_rdata n=%0d a=%h got=%h want=%h", n, a, csr_rdata_o, exp_d); end
      end
      total++; if (ovf_o !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%h want=%h", n, ovf_o, m_ovf); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mcycle_idle();
    test_event_count();
    test_overflow();
    test_inhibit();
    test_rw_simul();
    test_priv();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Machine-mode hardware performance monitor: `mcycle`, `minstret` and `NUM_HPM` event-selectable counters `mhpmcounter3..`. Each HPM counter has an `mhpmevent` selector, a global `mcountinhibit` and an `mcounteren`-gated user read-only shadow. The bank sits beside the CSR file in the execute stage, which forwards CSR accesses in the B00–B1F / C00–C1F / 320–33F / 306 ranges. Pipeline, cache and TLB event pulses feed it.

## Interface
Parameters:
- `XLEN`, 64, CSR data width.
- `NUM_HPM`, 14, number of HPM counters, 1..29; counter i is at B03+i.
- `NUM_EVENTS`, 16, width of the event pulse vector.
- `CNT_WIDTH`, 64, counter width, ≤ XLEN; zero-extended on read.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `csr_addr_i`  in  12  CSR address.
- `csr_rd_en_i`  in  1  read request.
- `csr_wr_en_i`  in  1  write request.
- `csr_wdata_i`  in  XLEN  write data.
- `priv_lvl_i`  in  2  current privilege: 0=U, 1=S, 3=M.
- `retire_i`  in  1  one instruction retired this cycle.
- `events_i`  in  NUM_EVENTS  single-cycle event pulses.
- `csr_rdata_o`  out  XLEN  read data.
- `csr_rvalid_o`  out  1  read or write response valid.
- `csr_illegal_o`  out  1  access rejected; qualified by `csr_rvalid_o`.
- `ovf_o`  out  NUM_HPM  sticky per-counter overflow flags.

## Operation
- Register map:
  - B00 `mcycle`; B02 `minstret`; B03+i `mhpmcounter(3+i)`.
  - C00/C02/C03+i are read-only shadows of the above.
  - 320 `mcountinhibit`: bit0 cycle, bit2 instret, bit3+i HPM i; bit1 reads 0.
  - 323+i `mhpmevent(3+i)`.
  - 306 `mcounteren`, same bit layout.
- Increment rule, evaluated each cycle:
  - `mcycle` += 1 unless inhibited.
  - `minstret` += `retire_i` unless inhibited.
  - HPM i += 1 when `sel = mhpmevent[i]` is in 1..NUM_EVENTS, `events_i[sel-1]` is set, and the counter is not inhibited.
  - sel=0 or sel>NUM_EVENTS counts nothing.
- Arithmetic: modulo 2^CNT_WIDTH. Wrap from all-ones to 0 sets `ovf_o[i]`. `ovf_o[i]` clears only when software writes HPM i.
- Writes:
  - A write to a counter loads `csr_wdata_i[CNT_WIDTH-1:0]` and suppresses that counter's increment in the same cycle; the write wins.
  - `mhpmevent` stores the low 8 bits.
  - `mcountinhibit` and `mcounteren` store implemented bits only.
- Legality, all flagged with `csr_illegal_o=1` and no state change:
  - Any write to C00–C1F.
  - A U/S access to any 3xx/Bxx address.
  - A U/S read of C-shadow bit k with `mcounteren[k]=0`.
  - Addresses beyond NUM_HPM; C01 (time).
  - An access in this window while `priv_lvl_i`=2.
- Simultaneous read and write (csrrw/csrrs): read returns the pre-write value; the write then applies.
- Reset values: all counters, `mhpmevent`, `mcountinhibit`, `mcounteren`, `ovf_o`, `csr_rdata_o`, `csr_rvalid_o` and `csr_illegal_o` are 0.

## Timing
- Read latency: 1 cycle. The request in cycle T produces `csr_rvalid_o`=1 with data/illegal in T+1, for one cycle.
- Write-only requests also produce a `csr_rvalid_o` pulse in T+1, with data 0.
- Write visible to a read issued in T+1 or later.
- Event/retire pulses in cycle T are reflected in counter value from T+1.
- Back-to-back requests every cycle are supported; there is no stall.
- `csr_rd_en_i`/`csr_wr_en_i` low: no response; `csr_rvalid_o`=0.
- Asserting reset mid-operation clears all state immediately; the first valid access is the first edge after release.

## Structure
- Shared package additions:
  - `CSR_MCOUNTINHIBIT`=12'h320 and `CSR_MHPMEVENT3`=12'h323 enum entries.
  - A `priv_lvl_t` enum (U=0, S=1, M=3).
  - Localparams `HPM_BASE_IDX`=3 and `MAX_HPM`=29.
- One sub-module, `hpm_counter`: a single counter with `inc_i`, `wr_en_i`, `wdata_i`, `cnt_o`, `ovf_o`. It is instantiated NUM_HPM+2 times in a generate loop (cycle and instret without the event mux).

## Test plan
- Reset release, idle 10 cycles → `mcycle` read at B00 returns 10 (±1 for read latency, exact value checked against the cycle model); all other counters 0.
- Write 323←5, pulse `events_i[4]` 7 times → B03 reads 7; pulse `events_i[3]` → still 7.
- Write B03←64'hFFFF_FFFF_FFFF_FFFE, two event pulses → reads 0, `ovf_o[0]`=1; write B03←0 → `ovf_o[0]`=0.
- `mcountinhibit`←1, wait 5 cycles → B00 frozen; clear → resumes counting.
- `priv_lvl_i`=U, read C03 with `mcounteren`=0 → `csr_illegal_o`=1; set bit3 → value returned. Write C00 → illegal, `mcycle` unchanged.
- Simultaneous rd+wr B03 with wdata=100 while an event pulses → old value returned; next read 100, the event increment is dropped.
